// File: rtl/apb_master_n.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_n
//  Description : APB master bridging a simple request/response port onto
//                NUM_SLV address-decoded APB slaves. Each slave owns a
//                2^SLV_AW byte window. The master has an ACCESS-phase timeout
//                and reports a decode miss as an error completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_n #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 4,
    parameter int                SLV_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int                TIMEOUT   = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    // request side
    input  logic                      transfer,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wstrb,
    // response side
    output logic                      ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy,
    // APB master outputs
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    // APB slave returns
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int                 c_IDX_W   = $clog2(NUM_SLV);
    localparam int                 c_DEC_LO  = SLV_AW + c_IDX_W;
    localparam logic [7:0]         c_TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_SLV-1:0] c_ONE     = {{(NUM_SLV-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_hit;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_tcnt;

    logic                 w_hit;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_pready;
    logic                 w_pslverr;
    logic [DATA_W-1:0]    w_prdata;

    // Region decode on the incoming request; only used when it is latched.
    assign w_hit = (addr[ADDR_W-1:c_DEC_LO] == BASE_ADDR[ADDR_W-1:c_DEC_LO]);
    assign w_idx = addr[SLV_AW +: c_IDX_W];

    // Select the returns of the addressed slave; all other slaves are ignored.
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == i[c_IDX_W-1:0]) begin
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
                w_prdata  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_tcnt  <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            PSEL    <= '0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (transfer) begin
                        PADDR   <= addr;
                        PWRITE  <= write;
                        // reads drive zero data and zero strobes
                        PWDATA  <= write ? wdata : '0;
                        PSTRB   <= write ? wstrb : '0;
                        r_hit   <= w_hit;
                        r_idx   <= w_idx;
                        PSEL    <= w_hit ? (c_ONE << w_idx) : '0;
                        busy    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_hit) begin
                        PENABLE <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_ACCESS;
                    end else begin
                        // nothing decoded: finish immediately with an error
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        ready   <= 1'b1;
                        err     <= w_pslverr;
                        rdata   <= PWRITE ? '0 : w_prdata;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_tcnt == c_TO_LAST) begin
                        // slave never answered within the allowed window
                        ready   <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_n
//  Description : Scoreboard bench for apb_master_n with a behavioural
//                four-slave APB model (per-slave wait states, hang, error).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_n;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          transfer;
    logic          t_write;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          ready;
    logic [31:0]   rdata;
    logic          err;
    logic          busy;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic          PWRITE;
    logic          PENABLE;
    logic [3:0]    PSEL;
    logic [127:0]  PRDATA;
    logic [3:0]    PREADY;
    logic [3:0]    PSLVERR;

    apb_master_n dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .transfer(transfer),
        .write   (t_write),
        .addr    (addr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .ready   (ready),
        .rdata   (rdata),
        .err     (err),
        .busy    (busy),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // slave model configuration
    int          waits  [4];
    logic        hang   [4];
    logic        slverr [4];
    logic [31:0] rdat   [4];
    int          wcnt   [4];

    // Selected slaves answer per configuration; unselected ones drive junk.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (PSEL[i]) begin
                PREADY[i]           = PENABLE && !hang[i] && (wcnt[i] >= waits[i]);
                PSLVERR[i]          = slverr[i];
                PRDATA[i*32 +: 32]  = rdat[i];
            end else begin
                PREADY[i]           = 1'b1;
                PSLVERR[i]          = 1'b1;
                PRDATA[i*32 +: 32]  = 32'hDEAD_0000 | 32'(i);
            end
        end
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (PSEL[i] && PENABLE && !PREADY[i]) wcnt[i] <= wcnt[i] + 1;
            else                                   wcnt[i] <= 0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse is matched against the next expectation.
    always @(negedge PCLK) begin
        if (PRESET !== 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdata", 64'(rdata), 64'(e.rdata));
                check("err", 64'(err), 64'(e.err));
                check("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive a request from the current negedge; lat counts cycles to ready.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee,
                         input int lat, input bit push);
        exp_t e;
        transfer = 1'b1;
        t_write  = w;
        addr     = a;
        wdata    = d;
        wstrb    = s;
        @(posedge PCLK);
        #1;
        transfer = 1'b0;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + lat - 1;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge PCLK);
            if (ready === 1'b1) seen = 1'b1;
        end
        if (!seen) check("ready_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            waits[i]  = 0;
            hang[i]   = 1'b0;
            slverr[i] = 1'b0;
            rdat[i]   = 32'h1111_0000 * 32'(i + 1);
        end
        PRESET   = 1'b1;
        transfer = 1'b0;
        t_write  = 1'b0;
        addr     = '0;
        wdata    = '0;
        wstrb    = '0;
        repeat (3) @(negedge PCLK);

        // reset state
        check("rst_psel", 64'(PSEL), 64'(0));
        check("rst_penable", 64'(PENABLE), 64'(0));
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_paddr", 64'(PADDR), 64'(0));
        PRESET = 1'b0;
        @(negedge PCLK);

        // zero-wait write to slave 0
        issue(1'b1, 32'h1000_0004, 32'd11, 4'hF, 32'h0, 1'b0, 3, 1'b1);
        check("w_setup_psel", 64'(PSEL), 64'(4'b0001));
        check("w_setup_penable", 64'(PENABLE), 64'(0));
        check("w_pstrb", 64'(PSTRB), 64'(4'hF));
        check("w_pwrite", 64'(PWRITE), 64'(1));
        check("w_pwdata", 64'(PWDATA), 64'(11));
        check("w_paddr", 64'(PADDR), 64'(32'h1000_0004));
        check("w_busy", 64'(busy), 64'(1));
        @(posedge PCLK); #1;
        check("w_access_penable", 64'(PENABLE), 64'(1));
        check("w_access_psel", 64'(PSEL), 64'(4'b0001));
        wait_done();

        // read from slave 1 with two wait states
        waits[1] = 2;
        rdat[1]  = 32'hCAFE_0012;
        @(negedge PCLK);
        issue(1'b0, 32'h1000_1008, 32'hFFFF_FFFF, 4'hF, 32'hCAFE_0012, 1'b0, 5, 1'b1);
        check("r_setup_psel", 64'(PSEL), 64'(4'b0010));
        check("r_pstrb", 64'(PSTRB), 64'(0));
        check("r_pwdata", 64'(PWDATA), 64'(0));
        check("r_pwrite", 64'(PWRITE), 64'(0));
        wait_done();
        repeat (2) @(negedge PCLK);
        check("r_rdata_hold", 64'(rdata), 64'(32'hCAFE_0012));
        check("r_err_hold", 64'(err), 64'(0));

        // decode miss
        issue(1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 2, 1'b1);
        check("miss_psel", 64'(PSEL), 64'(0));
        check("miss_penable", 64'(PENABLE), 64'(0));
        check("miss_busy", 64'(busy), 64'(1));
        wait_done();
        check("miss_penable_end", 64'(PENABLE), 64'(0));

        // slave 3 never answers: 16 ACCESS cycles then timeout error
        hang[3] = 1'b1;
        @(negedge PCLK);
        issue(1'b0, 32'h1000_3000, 32'h0, 4'h0, 32'h0, 1'b1, 18, 1'b1);
        check("to_psel", 64'(PSEL), 64'(4'b1000));
        wait_done();
        check("to_psel_end", 64'(PSEL), 64'(0));
        check("to_busy_end", 64'(busy), 64'(0));

        // slave 2 error, then back-to-back write issued on the ready cycle
        slverr[2] = 1'b1;
        @(negedge PCLK);
        issue(1'b0, 32'h1000_2010, 32'h0, 4'h0, 32'h3333_0000, 1'b1, 3, 1'b1);
        check("se_psel", 64'(PSEL), 64'(4'b0100));
        wait_done();
        issue(1'b1, 32'h1000_0020, 32'h0000_ABCD, 4'h3, 32'h0, 1'b0, 3, 1'b1);
        check("b2b_psel", 64'(PSEL), 64'(4'b0001));
        check("b2b_pstrb", 64'(PSTRB), 64'(4'h3));
        wait_done();

        // reset during ACCESS aborts with no ready pulse
        @(negedge PCLK);
        issue(1'b0, 32'h1000_3004, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
        @(posedge PCLK); #1;
        check("abort_in_access", 64'(PENABLE), 64'(1));
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check("abort_psel", 64'(PSEL), 64'(0));
        check("abort_penable", 64'(PENABLE), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(ready), 64'(0));
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (20) @(negedge PCLK);

        check("queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
